// File: rtl/data_ram_arbiter_pkg.sv
// Shared types for the two-requester data RAM arbiter.
package data_ram_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  // Requester identifier: 0 -> r0, 1 -> r1.
  typedef logic [0:0] req_id_t;

  // StRd means a read was issued in the previous cycle and ram_dout is live now.
  typedef enum logic [0:0] {
    StIdle,
    StRd
  } state_e;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Requester and RAM signal bundle for data_ram_arbiter.
// slave: arbiter side. master: requesters plus RAM model side.
interface data_ram_arbiter_if #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned ADDR_WIDTH = 16
);

  logic                  r0_req;
  logic                  r0_we;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DWIDTH-1:0]     r0_wdata;
  logic                  r0_gnt;
  logic [DWIDTH-1:0]     r0_rdata;
  logic                  r0_rvalid;

  logic                  r1_req;
  logic                  r1_we;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DWIDTH-1:0]     r1_wdata;
  logic                  r1_gnt;
  logic [DWIDTH-1:0]     r1_rdata;
  logic                  r1_rvalid;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0]     ram_data;
  logic                  ram_we;
  logic [DWIDTH-1:0]     ram_dout;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  ram_dout,
    output r0_gnt, r0_rdata, r0_rvalid,
    output r1_gnt, r1_rdata, r1_rvalid,
    output ram_addr, ram_data, ram_we
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output ram_dout,
    input  r0_gnt, r0_rdata, r0_rvalid,
    input  r1_gnt, r1_rdata, r1_rvalid,
    input  ram_addr, ram_data, ram_we
  );

endinterface

// File: rtl/data_ram_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter. Requests arrive already filtered, so a
// requester that was masked never moves the pointer and keeps its priority.
module rr_arbiter_2
  import data_ram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt
);

  // Most recently granted requester; reset value 1 hands the first tie to r0.
  req_id_t r_last;

  // Single requester wins outright; on a tie the one not granted last wins.
  always_comb begin
    o_gnt = '0;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last[0] ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

  // Pointer moves only when something is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (|o_gnt) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Arbitrates two requesters onto one single-port data RAM. Reads return two
// cycles after grant; writes are held off while a read result is on ram_dout.
module data_ram_arbiter
  import data_ram_arb_pkg::*;
#(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  data_ram_arbiter_if.slave  io_bus
);

  logic [NUM_REQ-1:0]    w_req;
  logic [NUM_REQ-1:0]    w_we;
  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [DWIDTH-1:0]     w_wdata [NUM_REQ];
  logic                  w_gnt_any;
  logic                  w_gnt_we;
  req_id_t               w_gnt_id;

  state_e                r_state;
  logic                  r_tag_vld;
  req_id_t               r_tag_id;
  logic [NUM_REQ-1:0]    r_rvalid;
  logic [DWIDTH-1:0]     r_rdata [NUM_REQ];

  assign w_req      = {io_bus.r1_req, io_bus.r0_req};
  assign w_we       = {io_bus.r1_we, io_bus.r0_we};
  assign w_addr[0]  = io_bus.r0_addr;
  assign w_addr[1]  = io_bus.r1_addr;
  assign w_wdata[0] = io_bus.r0_wdata;
  assign w_wdata[1] = io_bus.r1_wdata;

  // Reset blocks everything; a write in StRd would zero the in-flight ram_dout.
  always_comb begin
    w_elig = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      w_elig[n] = w_req[n] & ~rst & ~((r_state == StRd) & w_we[n]);
    end
  end

  rr_arbiter_2 u_rr_arbiter_2 (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_elig),
    .o_gnt (w_gnt)
  );

  assign w_gnt_any     = |w_gnt;
  assign w_gnt_id      = w_gnt[1];
  assign w_gnt_we      = w_gnt_any & w_we[w_gnt_id];
  assign io_bus.r0_gnt = w_gnt[0];
  assign io_bus.r1_gnt = w_gnt[1];

  // RAM port follows the granted requester, idles at zero otherwise.
  always_comb begin
    io_bus.ram_we   = 1'b0;
    io_bus.ram_addr = '0;
    io_bus.ram_data = '0;
    if (w_gnt_any) begin
      io_bus.ram_we   = w_we[w_gnt_id];
      io_bus.ram_addr = w_addr[w_gnt_id];
      io_bus.ram_data = w_wdata[w_gnt_id];
    end
  end

  // FSM plus read tag: records who issued the read whose data lands next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_tag_vld <= 1'b0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= w_gnt_any & ~w_gnt_we;
      r_tag_id  <= w_gnt_id;
      r_state   <= (w_gnt_any && !w_gnt_we) ? StRd : StIdle;
    end
  end

  // Capture ram_dout into the tagged requester; the other rdata holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= '0;
      for (int n = 0; n < NUM_REQ; n++) begin
        r_rdata[n] <= '0;
      end
    end else begin
      r_rvalid <= '0;
      if (r_tag_vld) begin
        r_rvalid[r_tag_id] <= 1'b1;
        r_rdata[r_tag_id]  <= io_bus.ram_dout;
      end
    end
  end

  assign io_bus.r0_rvalid = r_rvalid[0];
  assign io_bus.r1_rvalid = r_rvalid[1];
  assign io_bus.r0_rdata  = r_rdata[0];
  assign io_bus.r1_rdata  = r_rdata[1];

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed vector table, hand-written hazard and
// reset sequences, then constrained-random traffic against a reference model.
module tb_data_ram_arbiter;
  import data_ram_arb_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_ram_arbiter_if #(.DWIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_ram_arbiter #(.DWIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  // Single-port RAM: one-cycle read latency, output forced to 0 while writing.
  logic [DW-1:0] ram_mem [65536];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_data;
    ram_q <= ram_mem[bus.ram_addr];
  end
  assign bus.ram_dout = bus.ram_we ? '0 : ram_q;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  logic [DW-1:0] mdl_mem [65536];
  rd_t           m_q[$];
  int            m_last     = 1;
  bit            m_inflight = 1'b0;
  bit            m_synced   = 1'b0;
  int            m_gid      = -1;
  logic          m_rvalid [2];
  logic [DW-1:0] m_rdata  [2];

  function automatic logic f_we(int id);
    return (id == 0) ? bus.r0_we : bus.r1_we;
  endfunction
  function automatic logic [AW-1:0] f_addr(int id);
    return (id == 0) ? bus.r0_addr : bus.r1_addr;
  endfunction
  function automatic logic [DW-1:0] f_wdata(int id);
    return (id == 0) ? bus.r0_wdata : bus.r1_wdata;
  endfunction

  // Who should be granted this cycle, from the arbitration rules.
  task automatic mdl_comb();
    bit e0, e1;
    e0 = bus.r0_req && !rst && !(m_inflight && bus.r0_we);
    e1 = bus.r1_req && !rst && !(m_inflight && bus.r1_we);
    if (e0 && e1)  m_gid = 1 - m_last;
    else if (e0)   m_gid = 0;
    else if (e1)   m_gid = 1;
    else           m_gid = -1;
  endtask

  task automatic mdl_check();
    chk("mdl_gnt0", 32'(bus.r0_gnt), 32'(m_gid == 0));
    chk("mdl_gnt1", 32'(bus.r1_gnt), 32'(m_gid == 1));
    chk("mdl_ram_we", 32'(bus.ram_we), 32'((m_gid >= 0) && f_we(m_gid)));
    chk("mdl_ram_addr", 32'(bus.ram_addr), (m_gid >= 0) ? 32'(f_addr(m_gid)) : 32'd0);
    if (m_gid < 0 || f_we(m_gid))
      chk("mdl_ram_data", 32'(bus.ram_data), (m_gid >= 0) ? 32'(f_wdata(m_gid)) : 32'd0);
    if (m_synced) begin
      chk("mdl_rvalid0", 32'(bus.r0_rvalid), 32'(m_rvalid[0]));
      chk("mdl_rvalid1", 32'(bus.r1_rvalid), 32'(m_rvalid[1]));
      chk("mdl_rdata0", 32'(bus.r0_rdata), 32'(m_rdata[0]));
      chk("mdl_rdata1", 32'(bus.r1_rdata), 32'(m_rdata[1]));
    end
  endtask

  // Clock edge: reads return two cycles after grant, reset drops everything.
  task automatic mdl_seq();
    rd_t r;
    if (rst) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_last     = 1;
      m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0;
      m_rdata[0]  = '0;   m_rdata[1]  = '0;
      m_synced   = 1'b1;
    end else begin
      m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == cyc + 1) begin
        r = m_q.pop_front();
        m_rvalid[r.id] = 1'b1;
        m_rdata[r.id]  = r.data;
      end
      if (m_gid >= 0) begin
        m_last = m_gid;
        if (f_we(m_gid)) begin
          mdl_mem[f_addr(m_gid)] = f_wdata(m_gid);
          m_inflight = 1'b0;
        end else begin
          r.id   = m_gid;
          r.data = mdl_mem[f_addr(m_gid)];
          r.due  = cyc + 2;
          m_q.push_back(r);
          m_inflight = 1'b1;
        end
      end else begin
        m_inflight = 1'b0;
      end
    end
    cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r, input logic q0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic q1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    rst = r;
    bus.r0_req = q0; bus.r0_we = w0; bus.r0_addr = a0; bus.r0_wdata = d0;
    bus.r1_req = q1; bus.r1_we = w1; bus.r1_addr = a1; bus.r1_wdata = d1;
  endtask

  task automatic idle(input logic r);
    drive(r, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic half();
    mdl_comb();
    @(negedge clk);
    mdl_check();
  endtask

  task automatic adv();
    @(posedge clk);
    mdl_seq();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic          q0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          q1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1;
    logic          co;
    logic          v0, v1;
    logic [DW-1:0] rd0, rd1;
  } vec_t;

  localparam int NVEC = 16;
  vec_t tbl [NVEC];

  bit            act [2];
  logic          rw  [2];
  logic [AW-1:0] ra  [2];
  logic [DW-1:0] rdt [2];

  initial begin
    // Reset with both writers asserted, then four contended write cycles.
    tbl[0]  = '{1, 1,1,16'h0100,16'hA000, 1,1,16'h0200,16'hB000, 0,0, 0, 0,0,16'h0000,16'h0000};
    tbl[1]  = '{1, 1,1,16'h0100,16'hA000, 1,1,16'h0200,16'hB000, 0,0, 1, 0,0,16'h0000,16'h0000};
    tbl[2]  = '{0, 1,1,16'h0100,16'hA000, 1,1,16'h0200,16'hB000, 1,0, 1, 0,0,16'h0000,16'h0000};
    tbl[3]  = '{0, 1,1,16'h0101,16'hA001, 1,1,16'h0200,16'hB000, 0,1, 1, 0,0,16'h0000,16'h0000};
    tbl[4]  = '{0, 1,1,16'h0101,16'hA001, 1,1,16'h0201,16'hB001, 1,0, 1, 0,0,16'h0000,16'h0000};
    tbl[5]  = '{0, 1,1,16'h0102,16'hA002, 1,1,16'h0201,16'hB001, 0,1, 1, 0,0,16'h0000,16'h0000};
    tbl[6]  = '{0, 1,1,16'h0102,16'hA002, 0,0,16'h0000,16'h0000, 1,0, 1, 0,0,16'h0000,16'h0000};
    // Single read of 0x0010, data two cycles later.
    tbl[7]  = '{0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 1,0, 1, 0,0,16'h0000,16'h0000};
    tbl[8]  = '{0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0, 1, 0,0,16'h0000,16'h0000};
    tbl[9]  = '{0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0, 1, 1,0,16'hBEEF,16'h0000};
    // Back-to-back reads of 1, 2, 3.
    tbl[10] = '{0, 1,0,16'h0001,16'h0000, 0,0,16'h0000,16'h0000, 1,0, 1, 0,0,16'hBEEF,16'h0000};
    tbl[11] = '{0, 1,0,16'h0002,16'h0000, 0,0,16'h0000,16'h0000, 1,0, 1, 0,0,16'hBEEF,16'h0000};
    tbl[12] = '{0, 1,0,16'h0003,16'h0000, 0,0,16'h0000,16'h0000, 1,0, 1, 1,0,16'h1111,16'h0000};
    tbl[13] = '{0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0, 1, 1,0,16'h2222,16'h0000};
    tbl[14] = '{0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0, 1, 1,0,16'h3333,16'h0000};
    tbl[15] = '{0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0, 1, 0,0,16'h3333,16'h0000};

    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = '0;
      mdl_mem[i] = '0;
    end
    ram_mem[16'h0010] = 16'hBEEF; mdl_mem[16'h0010] = 16'hBEEF;
    ram_mem[16'h0001] = 16'h1111; mdl_mem[16'h0001] = 16'h1111;
    ram_mem[16'h0002] = 16'h2222; mdl_mem[16'h0002] = 16'h2222;
    ram_mem[16'h0003] = 16'h3333; mdl_mem[16'h0003] = 16'h3333;
    ram_mem[16'h0020] = 16'h5A5A; mdl_mem[16'h0020] = 16'h5A5A;
    for (int i = 16'h40; i < 16'h48; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      ram_mem[i] = v;
      mdl_mem[i] = v;
    end

    idle(1'b1);
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rst, tbl[i].q0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].q1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      half();
      chk($sformatf("tbl%0d_gnt0", i), 32'(bus.r0_gnt), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(bus.r1_gnt), 32'(tbl[i].g1));
      if (tbl[i].co) begin
        chk($sformatf("tbl%0d_rvalid0", i), 32'(bus.r0_rvalid), 32'(tbl[i].v0));
        chk($sformatf("tbl%0d_rvalid1", i), 32'(bus.r1_rvalid), 32'(tbl[i].v1));
        chk($sformatf("tbl%0d_rdata0", i), 32'(bus.r0_rdata), 32'(tbl[i].rd0));
        chk($sformatf("tbl%0d_rdata1", i), 32'(bus.r1_rdata), 32'(tbl[i].rd1));
      end
      adv();
    end

    // Read of 0x20 followed by a write to 0x20: write waits one cycle.
    drive(1'b0, 1'b1, 1'b0, 16'h0020, '0, 1'b0, 1'b0, '0, '0);
    half(); chk("hz_rd_gnt0", 32'(bus.r0_gnt), 32'd1); adv();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h0020, 16'h1234);
    half(); chk("hz_wr_withheld", 32'(bus.r1_gnt), 32'd0);
    chk("hz_no_ram_we", 32'(bus.ram_we), 32'd0); adv();
    half(); chk("hz_wr_gnt1", 32'(bus.r1_gnt), 32'd1);
    chk("hz_ram_we", 32'(bus.ram_we), 32'd1);
    chk("hz_ram_data", 32'(bus.ram_data), 32'h1234);
    chk("hz_rvalid0", 32'(bus.r0_rvalid), 32'd1);
    chk("hz_rdata0_old", 32'(bus.r0_rdata), 32'h5A5A); adv();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0020, '0);
    half(); chk("hz_rb_gnt1", 32'(bus.r1_gnt), 32'd1); adv();
    idle(1'b0);
    half(); adv();
    half(); chk("hz_rb_rvalid1", 32'(bus.r1_rvalid), 32'd1);
    chk("hz_rb_rdata1", 32'(bus.r1_rdata), 32'h1234); adv();

    // Reset while r1's read is in flight; a writer is also asserted during reset.
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0010, '0);
    half(); chk("rs_gnt1", 32'(bus.r1_gnt), 32'd1); adv();
    drive(1'b1, 1'b1, 1'b1, 16'h0030, 16'hFFFF, 1'b0, 1'b0, '0, '0);
    half(); chk("rs_gnt0_blocked", 32'(bus.r0_gnt), 32'd0);
    chk("rs_gnt1_low", 32'(bus.r1_gnt), 32'd0);
    chk("rs_ram_we", 32'(bus.ram_we), 32'd0); adv();
    idle(1'b0);
    half(); chk("rs_rvalid1", 32'(bus.r1_rvalid), 32'd0);
    chk("rs_rvalid0", 32'(bus.r0_rvalid), 32'd0);
    chk("rs_rdata0", 32'(bus.r0_rdata), 32'd0);
    chk("rs_rdata1", 32'(bus.r1_rdata), 32'd0); adv();
    drive(1'b0, 1'b1, 1'b0, 16'h0001, '0, 1'b1, 1'b0, 16'h0002, '0);
    half(); chk("rs_tie_gnt0", 32'(bus.r0_gnt), 32'd1);
    chk("rs_tie_gnt1", 32'(bus.r1_gnt), 32'd0); adv();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0002, '0);
    half(); chk("rs_b2b_gnt1", 32'(bus.r1_gnt), 32'd1); adv();
    idle(1'b0);
    half(); chk("rs_rvalid0_b", 32'(bus.r0_rvalid), 32'd1);
    chk("rs_rdata0_b", 32'(bus.r0_rdata), 32'h1111); adv();
    half(); chk("rs_rvalid1_b", 32'(bus.r1_rvalid), 32'd1);
    chk("rs_rdata1_b", 32'(bus.r1_rdata), 32'h2222); adv();

    // Random traffic: each requester holds its request until granted.
    act[0] = 1'b0; act[1] = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && $urandom_range(0, 2) != 0) begin
          act[n] = 1'b1;
          rw[n]  = 1'($urandom_range(0, 1));
          ra[n]  = AW'(16'h40 + $urandom_range(0, 7));
          rdt[n] = DW'($urandom);
        end
      end
      drive(1'($urandom_range(0, 99) == 0), act[0], rw[0], ra[0], rdt[0],
            act[1], rw[1], ra[1], rdt[1]);
      half();
      adv();
      if (m_gid >= 0) act[m_gid] = 1'b0;
    end

    idle(1'b0);
    for (int k = 0; k < 4; k++) begin
      half();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
